// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_fsm
// Purpose  : Main control FSM for a multicycle ARM core. It sequences the
//            shared memory/ALU/IR/PC datapath through fetch, decode, execute
//            and writeback. It emits raw (pre-condition) enables and the
//            datapath mux selects.
// Ports    : Clk, Rst (async, active-low)
//            Op[1:0], Funct[5:0]       instruction fields from the IR
//            MemReady                  (only with FSM_MEMREADY_EN) memory handshake
//            IRWrite, NextPC, RegW,
//            MemW, Branch              raw enables
//            AdrSrc, ALUSrcA, ALUSrcB,
//            ResultSrc, ALUOp          datapath selects
//            IllegalOp                 pulse in DECODE for Op=11
//            State[STATE_W-1:0]        current state code, debug
// Options  : FSM_MEMREADY_EN - FETCH/MEMREAD/MEMWRITE wait for MemReady.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm #(
  parameter int STATE_W = 4  // must be >= 4; upper bits read as zero
) (
  input  logic               Clk,
  input  logic               Rst,
`ifdef FSM_MEMREADY_EN
  input  logic               MemReady,
`endif
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               ALUOp,
  output logic               NextPC,
  output logic               RegW,
  output logic               MemW,
  output logic               Branch,
  output logic               IllegalOp,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t state_q;
  state_t state_d;

  logic mem_ready;
`ifdef FSM_MEMREADY_EN
  assign mem_ready = MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  // Only I (bit 5) and L/S (bit 0) steer the sequence.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  logic irwrite_raw;
  logic nextpc_raw;
  logic regw_raw;
  logic memw_raw;
  logic branch_raw;
  logic illegal_raw;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = S_FETCH;
    irwrite_raw = 1'b0;
    nextpc_raw  = 1'b0;
    regw_raw    = 1'b0;
    memw_raw    = 1'b0;
    branch_raw  = 1'b0;
    illegal_raw = 1'b0;
    AdrSrc      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ResultSrc   = 2'b00;
    ALUOp       = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        // IR load and PC+4 fire only on the cycle the read completes.
        irwrite_raw = mem_ready;
        nextpc_raw  = mem_ready;
        state_d     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        illegal_raw = (Op == 2'b11);
        case (Op)
          2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        regw_raw  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        memw_raw = mem_ready;
        state_d  = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALUOp   = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regw_raw = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        branch_raw = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;  // codes 10..15: recover, all enables low
    endcase
  end

  // Reset forces state to FETCH, whose Moore decode would raise IRWrite and
  // NextPC; the enables are therefore also masked by Rst directly.
  assign IRWrite   = irwrite_raw & Rst;
  assign NextPC    = nextpc_raw  & Rst;
  assign RegW      = regw_raw    & Rst;
  assign MemW      = memw_raw    & Rst;
  assign Branch    = branch_raw  & Rst;
  assign IllegalOp = illegal_raw & Rst;
  assign State     = STATE_W'(state_q);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl_fsm
// Purpose  : Scoreboard bench for multicycle_ctrl_fsm. The stimulus process
//            turns each instruction into its expected state path, drives it
//            cycle by cycle and queues the expected state/outputs. A monitor
//            pops and compares on every falling edge.
// Options  : honours FSM_MEMREADY_EN (random memory stalls).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

  localparam int STATE_W = 6;

  logic               Clk = 1'b0;
  logic               Rst = 1'b1;
  logic [1:0]         Op = 2'b00;
  logic [5:0]         Funct = 6'b0;
`ifdef FSM_MEMREADY_EN
  logic               MemReady = 1'b1;
`endif
  logic               IRWrite, AdrSrc, ALUSrcA, ALUOp, NextPC;
  logic               RegW, MemW, Branch, IllegalOp;
  logic [1:0]         ALUSrcB, ResultSrc;
  logic [STATE_W-1:0] State;

  multicycle_ctrl_fsm #(.STATE_W(STATE_W)) dut (
    .Clk(Clk), .Rst(Rst),
`ifdef FSM_MEMREADY_EN
    .MemReady(MemReady),
`endif
    .Op(Op), .Funct(Funct),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUOp(ALUOp), .NextPC(NextPC), .RegW(RegW),
    .MemW(MemW), .Branch(Branch), .IllegalOp(IllegalOp), .State(State)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic [12:0] outs;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  logic [12:0] act_outs;
  assign act_outs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
                     NextPC, RegW, MemW, Branch, IllegalOp};

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Output table by state, straight from the per-state output list.
  function automatic logic [12:0] exp_outs(int s, bit rdy, logic [1:0] op);
    logic irw = 1'b0, adr = 1'b0, sa = 1'b0, aop = 1'b0, nx = 1'b0;
    logic rw = 1'b0, mw = 1'b0, br = 1'b0, il = 1'b0;
    logic [1:0] sb = 2'b00, rs = 2'b00;
    case (s)
      0: begin sa = 1'b1; sb = 2'b10; rs = 2'b10; irw = rdy; nx = rdy; end
      1: begin sa = 1'b1; sb = 2'b10; rs = 2'b10; il = (op == 2'b11); end
      2: sb = 2'b01;
      3: adr = 1'b1;
      4: begin rs = 2'b01; rw = 1'b1; end
      5: begin adr = 1'b1; mw = rdy; end
      6: aop = 1'b1;
      7: begin sb = 2'b01; aop = 1'b1; end
      8: rw = 1'b1;
      9: begin sb = 2'b01; rs = 2'b10; br = 1'b1; end
      default: ;
    endcase
    return {irw, adr, sa, sb, rs, aop, nx, rw, mw, br, il};
  endfunction

  // Drive one cycle: real Op/Funct only where the FSM looks at them, noise
  // elsewhere so any combinational leak shows up.
  task automatic drive(int s, bit rdy, logic [1:0] op, logic [5:0] fn);
    if (s == 1 || s == 2) begin
      Op = op; Funct = fn;
    end else begin
      Op = 2'($urandom); Funct = 6'($urandom);
    end
`ifdef FSM_MEMREADY_EN
    MemReady = rdy;
`endif
    sb_q.push_back('{st: 4'(s), outs: exp_outs(s, rdy, op)});
  endtask

  task automatic cycle(int s, bit rdy, logic [1:0] op, logic [5:0] fn);
    drive(s, rdy, op, fn);
    @(posedge Clk); #1;
  endtask

  function automatic bit is_mem_state(int s);
    return (s == 0 || s == 3 || s == 5);
  endfunction

  // fetch_stall < 0 picks a random stall length.
  task automatic run_instr(logic [1:0] op, logic [5:0] fn, int fetch_stall);
    int path[$];
    int k;
    path = {0, 1};
    case (op)
      2'b00: begin path.push_back(fn[5] ? 7 : 6); path.push_back(8); end
      2'b01: begin
        path.push_back(2);
        if (fn[0]) begin path.push_back(3); path.push_back(4); end
        else       path.push_back(5);
      end
      2'b10: path.push_back(9);
      default: ;
    endcase
    foreach (path[i]) begin
      k = 0;
`ifdef FSM_MEMREADY_EN
      if (is_mem_state(path[i]))
        k = (path[i] == 0 && fetch_stall >= 0) ? fetch_stall : int'($urandom_range(0, 2));
`else
      if (fetch_stall > 1000) k = 0;
`endif
      repeat (k) cycle(path[i], 1'b0, op, fn);
      cycle(path[i], is_mem_state(path[i]) ? 1'b1 : 1'($urandom), op, fn);
    end
  endtask

  // LDR aborted by reset while in MEMREAD.
  task automatic reset_mid_ldr();
    cycle(0, 1'b1, 2'b01, 6'b011001);
    cycle(1, 1'b1, 2'b01, 6'b011001);
    cycle(2, 1'b1, 2'b01, 6'b011001);
    drive(3, 1'b1, 2'b01, 6'b011001);
    @(negedge Clk); #2;
    Rst = 1'b0;
    #1;
    check("async_reset_state", 32'(State), 32'd0);
    check("async_reset_enables", {IRWrite, NextPC, RegW, MemW, Branch, IllegalOp}, 32'd0);
    repeat (2) begin
      @(negedge Clk);
      check("abort_no_regw", {State, RegW, MemW}, 32'd0);
    end
    @(posedge Clk); #1;
    Rst = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge Clk);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("state", 32'(State), 32'(mon_e.st));
        check("outputs", 32'(act_outs), 32'(mon_e.outs));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    #1 Rst = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      Op = 2'($urandom); Funct = 6'($urandom);
      check("reset_state", 32'(State), 32'd0);
      check("reset_enables", {IRWrite, NextPC, RegW, MemW, Branch, IllegalOp}, 32'd0);
      check("reset_selects", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp},
            {1'b0, 1'b1, 2'b10, 2'b10, 1'b0});
    end
    @(posedge Clk); #1;
    Rst = 1'b1;

    run_instr(2'b01, 6'b011001, 2);   // LDR, with a two-cycle fetch stall
    run_instr(2'b01, 6'b011000, -1);  // STR
    run_instr(2'b00, 6'b001000, -1);  // ADD reg
    run_instr(2'b00, 6'b101000, -1);  // ADD imm
    run_instr(2'b10, 6'b000000, -1);  // B
    run_instr(2'b11, 6'b000000, -1);  // undefined
    reset_mid_ldr();
    run_instr(2'b01, 6'b011001, -1);  // recovery after abort

    repeat (150) run_instr(2'($urandom), 6'($urandom), -1);

    repeat (3) @(negedge Clk);
    #1;
    check("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main control FSM for the multicycle ARM core; sequences the shared datapath (single memory, single ALU, IR, PC) through fetch/decode/execute/writeback.
- Emits raw (pre-condition-check) enables PCS/RegW/MemW plus mux selects.
- Downstream conditional logic gates those enables with CondEx.
- Decodes Op/Funct from the instruction register.

Parameters:
STATE_W, 4, width of the State register/debug port; must be >= 4; upper bits zero.

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  asynchronous reset, active-low
Op  input  2  instruction bits [27:26]: 00 data-proc, 01 memory, 10 branch, 11 undefined
Funct  input  6  instruction bits [25:20]; Funct[5]=I (immediate), Funct[0]=L/S
IRWrite  output  1  load instruction register
AdrSrc  output  1  memory address select: 0 PC, 1 ALUResult register
ALUSrcA  output  1  0 register A, 1 PC
ALUSrcB  output  2  00 register WriteData, 01 ExtImm, 10 constant 4
ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
ALUOp  output  1  1 = use Funct-based ALU decode, 0 = ADD
NextPC  output  1  PC update from ALU (fetch increment)
RegW  output  1  raw register-write enable
MemW  output  1  raw memory-write enable
Branch  output  1  raw branch enable (ORed with NextPC into PCS downstream)
IllegalOp  output  1  one-cycle pulse in DECODE when Op=11
State  output  STATE_W  current state encoding, debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9. Codes 10+ are unreachable; if entered, next state is FETCH and all enables are 0.
- Rst low: State=FETCH immediately (async). While Rst is low, IRWrite/NextPC/RegW/MemW/Branch/IllegalOp=0. Selects take their FETCH values.
- Outputs are a Moore decode of State only (no combinational Op/Funct path), except IllegalOp = (State==DECODE)&(Op==11).
- Each state lasts exactly one cycle. Transitions:
  FETCH->DECODE.
  DECODE: Op=01->MEMADR; Op=00&Funct[5]=0->EXECUTER; Op=00&Funct[5]=1->EXECUTEI; Op=10->BRANCH; Op=11->FETCH.
  MEMADR: Funct[0]=1->MEMREAD, else MEMWRITE.
  MEMREAD->MEMWB->FETCH. MEMWRITE->FETCH. EXECUTER/EXECUTEI->ALUWB->FETCH. BRANCH->FETCH.
- Per-state outputs; unlisted outputs are 0:
  FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10, IRWrite=1, NextPC=1.
  DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0.
  MEMREAD: AdrSrc=1, ResultSrc=00.
  MEMWB: ResultSrc=01, RegW=1.
  MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1.
  EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  ALUWB: ResultSrc=00, RegW=1.
  BRANCH: ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1.
- Instruction latency in cycles: LDR 5, STR 4, data-proc 4, branch 3, undefined 2.
- Reset asserted mid-instruction: FSM aborts to FETCH. No RegW/MemW pulse is emitted for the aborted instruction.

Optional Feature:
- Macro FSM_MEMREADY_EN.
- Defined: adds input MemReady (1 bit). FETCH, MEMREAD and MEMWRITE hold while MemReady=0, with outputs held at their state values; advance on the cycle MemReady=1.
  - IRWrite, NextPC and MemW are asserted only in the cycle where MemReady=1, so each fires exactly once per access.
- Undefined: no MemReady port; memory is treated as always ready; behaviour is exactly as above.

Test Plan:
- Reset: hold Rst=0 3 cycles, release -> State=0, all enables 0 during reset; cycle after release IRWrite=1, NextPC=1.
- LDR (Op=01, Funct=011001) -> State sequence 0,1,2,3,4,0; RegW=1 only in state 4 with ResultSrc=01.
- STR (Op=01, Funct=011000) -> sequence 0,1,2,5,0; MemW=1 only in state 5 with AdrSrc=1; RegW never 1.
- ADD reg (Op=00, Funct=001000) -> 0,1,6,8,0 with ALUSrcB=00, ALUOp=1 in state 6. ADD imm (Funct=101000) -> state 7 with ALUSrcB=01.
- B (Op=10) -> 0,1,9,0, Branch=1 in state 9. Op=11 -> IllegalOp=1 in DECODE, then State=0.
- Reset pulse in state 3 of an LDR -> State=0 asynchronously, no RegW pulse. With FSM_MEMREADY_EN: MemReady=0 for 2 cycles in FETCH -> State stays 0, IRWrite pulses once.
